// File: rtl/uart_buf_pkg.sv
// Shared definitions for the uart_buf MMIO UART.
//   uart_addr_t      : register index on the MMIO request port
//   uart_baud_rate_t : selectable reset baud rates
//   uart_status_t    : layout of the CTRL status bits [4:0]
//   uart_state_t     : common IDLE/START/DATA/STOP encoding for TX and RX
//   is_pow2 / clamp_div : elaboration and divisor helpers
package uart_buf_pkg;

  // Address space of the block in bytes.
  localparam int unsigned UART_SIZE = 16;

  // Shortest bit period in clocks; the RX half-bit sample needs at least 2.
  localparam logic [15:0] UART_DIV_MIN = 16'd4;

  typedef enum logic [1:0] {
    UART_CTRL = 2'd0,
    UART_RX   = 2'd1,
    UART_TX   = 2'd2,
    UART_DIV  = 2'd3
  } uart_addr_t;

  typedef enum int unsigned {
    BR_9600   = 9600,
    BR_19200  = 19200,
    BR_38400  = 38400,
    BR_57600  = 57600,
    BR_115200 = 115200,
    BR_230400 = 230400,
    BR_460800 = 460800,
    BR_921600 = 921600
  } uart_baud_rate_t;

  typedef struct packed {
    logic tx_empty;    // [4]
    logic frame_err;   // [3]
    logic rx_overrun;  // [2]
    logic rx_valid;    // [1]
    logic tx_ready;    // [0]
  } uart_status_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  function automatic logic is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // Saturate a requested divisor into the legal 16-bit range.
  function automatic logic [15:0] clamp_div(input logic [31:0] v);
    if (v < 32'(UART_DIV_MIN)) return UART_DIV_MIN;
    if (v > 32'h0000_FFFF)     return 16'hFFFF;
    return v[15:0];
  endfunction

endpackage

// File: rtl/uart_buf_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO used for both the RX
// and TX byte queues of uart_buf.
//   clk, rst_n  : clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata : write strobe and data; ignored when full unless a pop
//                 happens in the same cycle
//   pop, rdata  : read strobe and head-of-queue data; pop on empty ignored
//   full, empty : occupancy flags
// A push and pop on an empty FIFO stores the word and pops nothing: there is
// no pass-through path from wdata to rdata.
module sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW + 1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push on full still lands.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers and count define validity, and
  // a reset-free array maps onto plain RAM/flops without reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_buf.sv
// uart_buf: MMIO UART with byte FIFOs on both directions, 8N1, LSB first.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : request strobe; always ready
//   req_addr/req_we     : register index (CTRL, RX, TX, DIV) and direction
//   req_wdata           : write data
//   rsp_valid/rsp_data  : read data, one cycle after the read request
//   serial_in           : asynchronous RX line
//   serial_out          : TX line, idle high
// Registers: CTRL reads status / write clears sticky errors, RX pops a byte,
// TX pushes a byte, DIV holds the bit period in clocks (minimum 4).
module uart_buf
  import uart_buf_pkg::*;
#(
  parameter int unsigned     CLK_FREQ_HZ = 100_000_000,
  parameter uart_baud_rate_t BAUD_RATE   = BR_115200,
  parameter int unsigned     FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  uart_addr_t  req_addr,
  input  logic        req_we,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  input  logic        serial_in,
  output logic        serial_out
);

  if (FIFO_DEPTH < 2 || !is_pow2(FIFO_DEPTH)) begin : g_depth_check
    $error("uart_buf: FIFO_DEPTH must be a power of two and at least 2");
  end

  localparam logic [15:0] DIV_RESET = clamp_div(32'(CLK_FREQ_HZ / 32'(BAUD_RATE)));

  // ---------------------------------------------------------------- decode
  logic rd_req, wr_req;
  logic tx_push, rx_pop, ctrl_wr, div_wr;
  logic unused_wdata;

  assign req_ready    = 1'b1;
  assign rd_req       = req_valid && !req_we;
  assign wr_req       = req_valid && req_we;
  assign tx_push      = wr_req && (req_addr == UART_TX);
  assign ctrl_wr      = wr_req && (req_addr == UART_CTRL);
  assign div_wr       = wr_req && (req_addr == UART_DIV);
  assign rx_pop       = rd_req && (req_addr == UART_RX);
  assign unused_wdata = ^req_wdata[31:16];

  // ---------------------------------------------------------------- FIFOs
  logic       tx_pop, tx_full, tx_fifo_empty;
  logic [7:0] tx_rdata;
  logic       rx_push, rx_full, rx_fifo_empty;
  logic [7:0] rx_rdata, rx_shift_q;

  sync_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .wdata (req_wdata[7:0]),
    .pop   (tx_pop),
    .rdata (tx_rdata),
    .full  (tx_full),
    .empty (tx_fifo_empty)
  );

  sync_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .wdata (rx_shift_q),
    .pop   (rx_pop),
    .rdata (rx_rdata),
    .full  (rx_full),
    .empty (rx_fifo_empty)
  );

  // ------------------------------------------------------ divisor, sticky
  logic [15:0] div_q;
  logic        rx_overrun_q, frame_err_q;
  logic        rx_overrun_set, frame_err_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q        <= DIV_RESET;
      rx_overrun_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      if (div_wr) div_q <= clamp_div({16'b0, req_wdata[15:0]});
      // A set in the same cycle as a CTRL write wins over the clear.
      if (rx_overrun_set)   rx_overrun_q <= 1'b1;
      else if (ctrl_wr)     rx_overrun_q <= 1'b0;
      if (frame_err_set)    frame_err_q  <= 1'b1;
      else if (ctrl_wr)     frame_err_q  <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- TX FSM
  uart_state_t tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [15:0] tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_out_q, tx_out_d;
  logic        tx_bit_end;

  assign tx_bit_end = (tx_cnt_q == tx_div_q - 16'd1);

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      ST_IDLE: begin
        if (!tx_fifo_empty) begin
          tx_pop     = 1'b1;
          tx_state_d = ST_START;
          tx_shift_d = tx_rdata;
          tx_div_d   = div_q;     // period is frozen for the whole frame
          tx_cnt_d   = '0;
        end
      end
      ST_START: begin
        if (tx_bit_end) begin
          tx_state_d = ST_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) tx_state_d = ST_STOP;
          else                  tx_bit_d   = tx_bit_q + 3'd1;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!tx_fifo_empty) begin
            tx_pop     = 1'b1;
            tx_state_d = ST_START;
            tx_shift_d = tx_rdata;
            tx_div_d   = div_q;
          end else begin
            tx_state_d = ST_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
    // Line level is registered from the next state so serial_out is glitch
    // free and changes on the same edge as the state.
    case (tx_state_d)
      ST_START: tx_out_d = 1'b0;
      ST_DATA:  tx_out_d = tx_shift_d[0];
      default:  tx_out_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_div_q   <= DIV_RESET;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_out_q   <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_out_q   <= tx_out_d;
    end
  end

  assign serial_out = tx_out_q;

  // ---------------------------------------------------------------- RX FSM
  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic        rx_fall;
  uart_state_t rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [15:0] rx_div_q, rx_div_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_d;
  logic        rx_half_end, rx_bit_end;

  // Two-flop synchroniser; rx_prev_q only delays the synchronised level for
  // edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= serial_in;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign rx_fall     = rx_prev_q && !rx_sync_q;
  assign rx_half_end = (rx_cnt_q == (rx_div_q >> 1) - 16'd1);
  assign rx_bit_end  = (rx_cnt_q == rx_div_q - 16'd1);

  always_comb begin
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q;
    rx_div_d      = rx_div_q;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    rx_push       = 1'b0;
    frame_err_set = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        if (rx_fall) begin
          rx_state_d = ST_START;
          rx_cnt_d   = '0;
          rx_div_d   = div_q;
        end
      end
      ST_START: begin
        if (rx_half_end) begin
          rx_cnt_d = '0;
          // A start bit that is high again at mid-bit was a glitch.
          if (!rx_sync_q) begin
            rx_state_d = ST_DATA;
            rx_bit_d   = '0;
          end else begin
            rx_state_d = ST_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_state_d = ST_IDLE;
          if (rx_sync_q) rx_push       = 1'b1;
          else           frame_err_set = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  // A pop in the same cycle makes room, so only an unserviced full overruns.
  assign rx_overrun_set = rx_push && rx_full && !rx_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_div_q   <= DIV_RESET;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // ---------------------------------------------------------- read path
  uart_status_t status;
  logic [31:0]  rd_data;
  logic         rsp_valid_q;
  logic [31:0]  rsp_data_q;

  always_comb begin
    status = '{
      tx_empty:   tx_fifo_empty && (tx_state_q == ST_IDLE),
      frame_err:  frame_err_q,
      rx_overrun: rx_overrun_q,
      rx_valid:   !rx_fifo_empty,
      tx_ready:   !tx_full
    };
  end

  always_comb begin
    rd_data = '0;
    case (req_addr)
      UART_CTRL: rd_data = {27'b0, status};
      UART_RX:   rd_data = rx_fifo_empty ? 32'd0 : {24'b0, rx_rdata};
      UART_DIV:  rd_data = {16'b0, div_q};
      default:   rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rd_req;
      if (rd_req) rsp_data_q <= rd_data;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_uart_buf.sv
// Scoreboard bench for uart_buf: stimulus pushes expected read data and
// expected TX bytes into queues; independent monitors on rsp_valid and on
// serial_out pop and compare.
module tb_uart_buf;
  import uart_buf_pkg::*;

  localparam int CLK_NS = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  uart_addr_t  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        serial_in, serial_out;

  uart_buf #(.CLK_FREQ_HZ(100_000_000), .BAUD_RATE(BR_115200), .FIFO_DEPTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_we     (req_we),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .serial_in  (serial_in),
    .serial_out (serial_out)
  );

  always #(CLK_NS / 2) clk = ~clk;

  int     n_checks = 0;
  int     n_errors = 0;
  longint cyc = 0;
  int     cur_div = 868;
  bit     b2b_mode = 1'b0;
  bit     b2b_first = 1'b0;
  bit     tx_rst_seen = 1'b0;

  typedef struct {
    logic [31:0] data;
    string       name;
    longint      cyc;
  } rd_exp_t;

  rd_exp_t    rd_q[$];
  logic [7:0] tx_q[$];

  always @(posedge clk) cyc++;
  always @(negedge rst_n) tx_rst_seen = 1'b1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Bus tasks are entered at a negedge and return at the next negedge, so
  // consecutive calls give back-to-back requests.
  task automatic mmio_write(input uart_addr_t a, input logic [31:0] d);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic mmio_read(input uart_addr_t a, input logic [31:0] exp, input string name);
    rd_exp_t e;
    e.data = exp; e.name = name; e.cyc = cyc;
    rd_q.push_back(e);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop_bit, input int div);
    serial_in = 1'b0;
    repeat (div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      repeat (div) @(negedge clk);
    end
    serial_in = stop_bit;
    repeat (div) @(negedge clk);
    serial_in = 1'b1;
  endtask

  // Response monitor: every rsp_valid must match the oldest outstanding read
  // and arrive exactly one cycle after it was issued.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
      if (rd_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rsp_unexpected: got rsp_data 0x%0h with no read outstanding", rsp_data);
      end else begin
        rd_exp_t e;
        e = rd_q.pop_front();
        check(e.name, rsp_data, e.data);
        check({e.name, "_latency"}, 32'(cyc - e.cyc), 32'd1);
      end
    end
  end

  // TX monitor: decodes frames mid-bit and compares against the TX queue.
  initial begin : tx_mon
    time        t_start, t_prev;
    logic       st_b, sp_b;
    logic [7:0] got_b;
    logic [7:0] exp_b;
    t_prev = 0;
    forever begin
      @(negedge serial_out);
      if (rst_n !== 1'b1) continue;
      t_start     = $time;
      tx_rst_seen = 1'b0;
      if (b2b_mode) begin
        if (!b2b_first) check("tx_gap_ns", 32'(t_start - t_prev), 32'(10 * cur_div * CLK_NS));
        b2b_first = 1'b0;
      end
      t_prev = t_start;
      repeat (cur_div / 2) @(negedge clk);
      st_b = serial_out;
      for (int i = 0; i < 8; i++) begin
        repeat (cur_div) @(negedge clk);
        got_b[i] = serial_out;
      end
      repeat (cur_div) @(negedge clk);
      sp_b = serial_out;
      if (tx_rst_seen) continue;
      if (tx_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL tx_unexpected: got frame byte 0x%0h with none queued", got_b);
      end else begin
        exp_b = tx_q.pop_front();
        check("tx_frame{stop,byte,start}", {22'b0, sp_b, got_b, st_b}, {22'b0, 1'b1, exp_b, 1'b0});
      end
    end
  end

  initial begin : watchdog
    #(2_000_000);
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] burst [9] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
    logic [7:0] rxb   [9] = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h5A, 8'hA5, 8'h3C, 8'hC3, 8'h7E};
    int k;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = UART_CTRL;
    req_wdata = '0; serial_in = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_serial_out", {31'b0, serial_out}, 32'd1);
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("req_ready", {31'b0, req_ready}, 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    mmio_read(UART_CTRL, 32'h11, "reset_ctrl");
    mmio_read(UART_DIV, 32'd868, "reset_div");
    mmio_read(UART_RX, 32'd0, "reset_rx_empty");
    repeat (2) @(negedge clk);

    // Single TX frame, DIV=8
    mmio_write(UART_DIV, 32'd8);
    cur_div = 8;
    tx_q.push_back(8'hA5);
    mmio_write(UART_TX, 32'hFFFF_FFA5);
    repeat (110) @(negedge clk);
    check("tx_single_drained", 32'(tx_q.size()), 32'd0);
    mmio_read(UART_CTRL, 32'h11, "tx_single_ctrl");

    // Back-to-back burst of 9 writes into an 8-deep FIFO
    b2b_mode = 1'b1; b2b_first = 1'b1;
    foreach (burst[i]) tx_q.push_back(burst[i]);
    foreach (burst[i]) mmio_write(UART_TX, {24'b0, burst[i]});
    repeat (800) @(negedge clk);
    check("tx_burst_left_le1", {31'b0, tx_q.size() <= 1}, 32'd1);
    tx_q.delete();
    b2b_mode = 1'b0;
    mmio_read(UART_CTRL, 32'h11, "tx_burst_ctrl");

    // RX frame and glitch, DIV=16
    mmio_write(UART_DIV, 32'd16);
    cur_div = 16;
    rx_frame(8'h3C, 1'b1, 16);
    repeat (5) @(negedge clk);
    mmio_read(UART_CTRL, 32'h13, "rx_ctrl_valid");
    mmio_read(UART_RX, 32'h3C, "rx_byte");
    mmio_read(UART_CTRL, 32'h11, "rx_ctrl_drained");
    serial_in = 1'b0;
    repeat (4) @(negedge clk);
    serial_in = 1'b1;
    repeat (60) @(negedge clk);
    mmio_read(UART_CTRL, 32'h11, "rx_glitch_ctrl");
    mmio_read(UART_RX, 32'd0, "rx_glitch_empty");

    // Overrun: 9 frames, no reads
    foreach (rxb[i]) begin
      rx_frame(rxb[i], 1'b1, 16);
      repeat (2) @(negedge clk);
    end
    mmio_read(UART_CTRL, 32'h17, "rx_overrun_ctrl");
    for (int i = 0; i < 8; i++) mmio_read(UART_RX, {24'b0, rxb[i]}, "rx_overrun_byte");
    mmio_read(UART_CTRL, 32'h15, "rx_after_drain_ctrl");

    // Frame error: low stop bit
    rx_frame(8'hE7, 1'b0, 16);
    repeat (20) @(negedge clk);
    mmio_read(UART_CTRL, 32'h1D, "rx_frame_err_ctrl");
    mmio_read(UART_RX, 32'd0, "rx_frame_err_nopush");
    mmio_write(UART_CTRL, 32'd0);
    mmio_read(UART_CTRL, 32'h11, "ctrl_clear_sticky");

    // Reset during TX bit 3 of 0x52 (bit 3 = 0)
    mmio_write(UART_DIV, 32'd8);
    cur_div = 8;
    mmio_write(UART_TX, 32'h52);
    mmio_write(UART_TX, 32'h77);
    mmio_write(UART_TX, 32'h88);
    k = 0;
    while (serial_out !== 1'b0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("tx_abort_start_seen", {31'b0, serial_out}, 32'd0);
    repeat (35) @(negedge clk);
    check("tx_abort_bit3_low", {31'b0, serial_out}, 32'd0);
    #2 rst_n = 1'b0;
    #1 check("tx_abort_serial_out_high", {31'b0, serial_out}, 32'd1);
    @(negedge clk);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    mmio_read(UART_CTRL, 32'h11, "post_reset_ctrl");
    mmio_read(UART_DIV, 32'd868, "post_reset_div");
    mmio_write(UART_DIV, 32'd2);
    mmio_read(UART_DIV, 32'd4, "div_clamp");
    mmio_write(UART_DIV, 32'd8);
    tx_q.push_back(8'hC3);
    mmio_write(UART_TX, 32'hC3);
    repeat (110) @(negedge clk);
    check("post_reset_tx_drained", 32'(tx_q.size()), 32'd0);
    mmio_read(UART_CTRL, 32'h11, "post_reset_tx_ctrl");

    repeat (5) @(negedge clk);
    check("rsp_outstanding", 32'(rd_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_buf.md
UART_BUF -- requirements
Module: uart_buf

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 100_000_000, core clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, type uart_baud_rate_t, default BR_115200, reset baud rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, entries per RX and TX FIFO; power of 2, >=2, checked with is_pow2 at elaboration.
REQ-004 SHALL have ports: clk  input  1  sole clock; all logic on posedge.
REQ-005 SHALL have ports: rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: req_valid  input  1  MMIO request strobe; req_ready  output  1  tied 1.
REQ-007 SHALL have ports: req_addr  input  2  register index (uart_addr_t); req_we  input  1  1=write, 0=read; req_wdata  input  32  write data.
REQ-008 SHALL have ports: rsp_valid  output  1  read data valid; rsp_data  output  32  read data.
REQ-009 SHALL have ports: serial_in  input  1  asynchronous RX line; serial_out  output  1  TX line, idle high.

Function
REQ-010 SHALL provide registers: CTRL(0) status, RX(1) pop, TX(2) push, DIV(3) baud divisor; frame 8N1, LSB first.
REQ-011 SHALL return CTRL status bits: [0] tx_ready = TX FIFO not full; [1] rx_valid = RX FIFO not empty; [2] rx_overrun, sticky; [3] frame_err, sticky; [4] tx_empty = TX FIFO empty and TX FSM IDLE; [31:5] zero.
REQ-012 SHALL clear both sticky bits on any CTRL write; if set and clear coincide, set wins.
REQ-013 SHALL assert rsp_valid exactly one cycle after an accepted read, for one cycle; writes produce no response.
REQ-014 SHALL pop the RX FIFO on an RX read and return {24'b0, byte}; an RX read on empty FIFO returns 0 and does not pop.
REQ-015 SHALL push req_wdata[7:0] on a TX write; a TX write when TX FIFO is full is dropped, with no other effect.
REQ-016 SHALL load DIV from req_wdata[15:0] on a DIV write; values below 4 clamp to 4; reads return {16'b0, DIV}.
REQ-017 SHALL make a new DIV value take effect at the next frame start on each of TX and RX; frames in flight keep the old period.
REQ-018 SHALL run TX FSM IDLE->START->DATA->STOP->IDLE, each bit lasting DIV clocks; DATA uses a 3-bit bit counter.
REQ-019 SHALL start TX from IDLE in the cycle after the TX FIFO becomes non-empty; it SHALL re-enter START directly from STOP end if the FIFO is non-empty (back-to-back, no idle bit).
REQ-020 SHALL synchronise serial_in through 2 flops before any use.
REQ-021 SHALL run RX FSM IDLE->START->DATA->STOP->IDLE: a falling edge starts the frame; the start bit is resampled at DIV/2 and returns to IDLE if high (glitch); data bits are sampled every DIV clocks thereafter.
REQ-022 SHALL push the byte at stop-bit sample if the stop bit is high; a low stop bit sets frame_err and discards the byte.
REQ-023 SHALL handle a push to a full RX FIFO as follows: byte discarded, rx_overrun set; a simultaneous pop and push on full SHALL succeed with no overrun.
REQ-024 SHALL allow simultaneous push and pop on each FIFO in one cycle, including when empty: no pass-through, pop is ignored.

Reset
REQ-025 SHALL on rst_n low, asynchronously: both FIFOs emptied, FSMs IDLE, serial_out=1, rsp_valid=0, rsp_data=0, sticky bits 0, DIV=CLK_FREQ_HZ/BAUD_RATE, synchroniser flops 1.
REQ-026 SHALL on reset mid-frame abort the frame immediately, force serial_out high within the same cycle, and require no recovery sequence.

Structure
REQ-027 SHALL add UART_DIV=2'd3 to uart_addr_t, add uart_status_t packed struct (bits [4:0]), and set UART_SIZE to 16 in the shared defines package.
REQ-028 SHALL implement both FIFOs as one sub-module sync_fifo (parameters DEPTH, W; ports push/pop/full/empty, same clk/rst_n).

Verification
REQ-029 SHALL verify reset: after rst_n deasserts, CTRL read -> rsp_data=0x11, DIV read -> 868 (100 MHz/115200).
REQ-030 SHALL verify TX: DIV=8, write TX 0xA5 -> serial_out low 8 clk, then bits 1,0,1,0,0,1,0,1 each 8 clk, high 8 clk; tx_empty=1 afterwards.
REQ-031 SHALL verify TX FIFO: DIV=8, 9 back-to-back TX writes with FIFO_DEPTH=8 -> the 9th is dropped only if the shifter has not popped; 8 or 9 contiguous frames with no idle gap, matched against a scoreboard.
REQ-032 SHALL verify RX: DIV=16, drive 0x3C frame then read RX -> 0x3C, rx_valid back to 0; a 4-clk start-bit glitch -> no push.
REQ-033 SHALL verify RX errors: 9 frames without reads -> rx_overrun=1 and first 8 bytes intact; a frame with low stop bit -> frame_err=1, no push; a CTRL write clears both.
REQ-034 SHALL verify resets: rst_n asserted during TX bit 3 -> serial_out=1 immediately, FIFOs empty, next frame correct; DIV write of 2 reads back 4.
